// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared constants and write-FSM state encoding for the spectrum bank store
package spectrum_pkg;
   localparam int NUM_BINS      = 256;
   localparam int BIN_ADDR_W    = 8;
   localparam int DEF_DATA_BITS = 9;
   localparam int DEF_MAX_VALUE = 440;
   typedef enum logic [1:0] {ST_INIT, ST_FILL, ST_PENDING} wr_state_t;
endpackage

// File: rtl/spectrum_bank_ram.sv
// spectrum_bank_ram: one NUM_BINS x DATA_BITS bin bank, sync write, registered read (EBR-inferable)
module spectrum_bank_ram #(
   parameter int DATA_BITS = 9,
   parameter int DEPTH     = 256,
   parameter int ADDR_W    = 8
) (
   input  logic                 clk_pixel,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    waddr,
   input  logic [DATA_BITS-1:0] wdata,
   input  logic [ADDR_W-1:0]    raddr,
   output logic [DATA_BITS-1:0] rdata
);
   logic [DATA_BITS-1:0] mem [DEPTH];
   // Unreset storage so the array maps onto block RAM; reads return old data on a same-address write
   always_ff @(posedge clk_pixel) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/spectrum_bank_ctrl.sv
// spectrum_bank_ctrl: double-buffered bin store with frame-boundary swap; SPECTRUM_CLAMP_EN enables value clamping
module spectrum_bank_ctrl
   import spectrum_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int MAX_VALUE = DEF_MAX_VALUE
) (
   input  logic                  clk_pixel,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_BITS-1:0]  wr_data,
   input  logic                  wr_last,
   input  logic [BIN_ADDR_W-1:0] rd_addr,
   output logic [DATA_BITS-1:0]  rd_data,
   output logic                  disp_bank,
   output logic                  swap_pulse,
   output logic                  frame_err
);
   wr_state_t             state;
   logic [BIN_ADDR_W-1:0] init_cnt, wr_cnt, ram_waddr;
   logic [DATA_BITS-1:0]  wdata_c, ram_wdata, rdata0, rdata1;
   logic                  xfer, in_init, we0, we1, rd_sel, rd_init;

   assign xfer = wr_valid && wr_ready;

`ifdef SPECTRUM_CLAMP_EN
   localparam logic [DATA_BITS-1:0] MAX_V = DATA_BITS'(MAX_VALUE);
   // Saturate oversized magnitudes so the plotted line stays inside the plot area
   always_comb wdata_c = (wr_data > MAX_V) ? MAX_V : wr_data;
`else
   // Store producer magnitudes unmodified
   always_comb wdata_c = wr_data;
`endif

   // INIT clears both banks in lockstep; otherwise only the non-displayed bank is written
   always_comb begin
      in_init   = state == ST_INIT;
      we0       = in_init || (xfer && disp_bank);
      we1       = in_init || (xfer && !disp_bank);
      ram_waddr = in_init ? init_cnt : wr_cnt;
      ram_wdata = in_init ? '0 : wdata_c;
   end

   // Write FSM: clear banks, fill the write bank, then hold off the producer until a frame boundary swap
   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         state      <= ST_INIT;
         init_cnt   <= '0;
         wr_cnt     <= '0;
         wr_ready   <= 1'b0;
         disp_bank  <= 1'b0;
         swap_pulse <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         swap_pulse <= 1'b0;
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == '1) begin
                  state    <= ST_FILL;
                  wr_cnt   <= '0;
                  wr_ready <= 1'b1;
               end
            end
            ST_FILL: if (xfer) begin
               wr_cnt <= wr_cnt + 1'b1;
               if ((wr_cnt == '1) ^ wr_last) frame_err <= 1'b1;
               if (wr_cnt == '1 || wr_last) begin
                  state    <= ST_PENDING;
                  wr_ready <= 1'b0;
               end
            end
            ST_PENDING: if (frame_start) begin
               state      <= ST_FILL;
               disp_bank  <= !disp_bank;
               wr_cnt     <= '0;
               wr_ready   <= 1'b1;
               swap_pulse <= 1'b1;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // Capture the bank selection and INIT mask alongside the registered RAM read
   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         rd_sel  <= 1'b0;
         rd_init <= 1'b1;
      end else begin
         rd_sel  <= disp_bank;
         rd_init <= in_init;
      end
   end

   assign rd_data = rd_init ? '0 : (rd_sel ? rdata1 : rdata0);

   spectrum_bank_ram #(.DATA_BITS(DATA_BITS), .DEPTH(NUM_BINS), .ADDR_W(BIN_ADDR_W)) u_bank0 (
      .clk_pixel (clk_pixel),
      .we        (we0),
      .waddr     (ram_waddr),
      .wdata     (ram_wdata),
      .raddr     (rd_addr),
      .rdata     (rdata0)
   );

   spectrum_bank_ram #(.DATA_BITS(DATA_BITS), .DEPTH(NUM_BINS), .ADDR_W(BIN_ADDR_W)) u_bank1 (
      .clk_pixel (clk_pixel),
      .we        (we1),
      .waddr     (ram_waddr),
      .wdata     (ram_wdata),
      .raddr     (rd_addr),
      .rdata     (rdata1)
   );
endmodule

// File: tb/tb_spectrum_bank_ctrl.sv
// tb_spectrum_bank_ctrl: scoreboard bench for the double-buffered spectrum bank store
module tb_spectrum_bank_ctrl;
   logic       clk_pixel = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [8:0] wr_data = '0;
   logic       wr_last = 1'b0;
   logic [7:0] rd_addr = '0;
   logic [8:0] rd_data;
   logic       disp_bank;
   logic       swap_pulse;
   logic       frame_err;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] model_bank [2][256];
   logic       model_disp = 1'b0;
   logic [8:0] pat [256];
   logic [8:0] exp_q [$];

   spectrum_bank_ctrl dut (
      .clk_pixel  (clk_pixel),
      .rst        (rst),
      .frame_start(frame_start),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_last    (wr_last),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .disp_bank  (disp_bank),
      .swap_pulse (swap_pulse),
      .frame_err  (frame_err)
   );

   always #5 clk_pixel = ~clk_pixel;

   function automatic logic [8:0] clamp(input logic [8:0] v);
`ifdef SPECTRUM_CLAMP_EN
      return (v > 9'd440) ? 9'd440 : v;
`else
      return v;
`endif
   endfunction

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic clear_model();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++) model_bank[b][i] = '0;
      model_disp = 1'b0;
   endtask

   task automatic issue_rd(input logic [7:0] a);
      rd_addr = a;
      exp_q.push_back(model_bank[model_disp][a]);
      tick();
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!wr_ready && t < 2000) begin
         tick();
         t++;
      end
      if (!wr_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL wr_ready_timeout: wr_ready=%0b after %0d cycles, required 1", wr_ready, t);
      end
   endtask

   task automatic send_frame(input int n, input bit last_on_end, input bit fs_on_last);
      for (int i = 0; i < n; i++) begin
         wr_valid    = 1'b1;
         wr_data     = pat[i];
         wr_last     = last_on_end && (i == n - 1);
         frame_start = fs_on_last && (i == n - 1);
         wait_ready();
         model_bank[!model_disp][i] = clamp(pat[i]);
         tick();
      end
      wr_valid    = 1'b0;
      wr_last     = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      clear_model();
      repeat (2) tick();
      n_cmp += 4;
      if (wr_ready !== 1'b0 || disp_bank !== 1'b0 || swap_pulse !== 1'b0 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: ready=%0b disp=%0b swap=%0b err=%0b, required all 0",
                  wr_ready, disp_bank, swap_pulse, frame_err);
      end
      rst = 1'b0;
      for (int i = 0; i < 256; i++) begin
         n_cmp++;
         if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL init_ready cycle %0d: wr_ready=%0b, required 0", i + 1, wr_ready);
         end
         issue_rd(8'($urandom_range(0, 255)));
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_data !== e) begin
            n_err++;
            $display("FAIL init_rd cycle %0d: rd_data=%0d, required %0d", i + 1, rd_data, e);
         end
      end
      n_cmp++;
      if (wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_cycle257: wr_ready=%0b, required 1", wr_ready);
      end
   endtask

   task automatic test_first_frame();
      logic [8:0] e;
      for (int i = 0; i < 256; i++) pat[i] = 9'(i);
      send_frame(256, 1'b1, 1'b0);
      n_cmp++;
      if (wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL pending_ready: wr_ready=%0b, required 0", wr_ready);
      end
      rd_addr = 8'd100;
      exp_q.push_back(model_bank[model_disp][100]);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_disp = !model_disp;
      e = exp_q.pop_front();
      n_cmp += 4;
      if (rd_data !== e) begin
         n_err++;
         $display("FAIL swap_edge_rd: rd_data=%0d, required %0d (old bank)", rd_data, e);
      end
      if (swap_pulse !== 1'b1 || disp_bank !== 1'b1 || wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL swap1: swap=%0b disp=%0b ready=%0b, required 1 1 1", swap_pulse, disp_bank, wr_ready);
      end
      issue_rd(8'd100);
      e = exp_q.pop_front();
      if (rd_data !== 9'd100 || e !== 9'd100) begin
         n_err++;
         $display("FAIL frame1_rd100: rd_data=%0d, required 100", rd_data);
      end
      if (swap_pulse !== 1'b0 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL swap1_after: swap=%0b err=%0b, required 0 0", swap_pulse, frame_err);
      end
   endtask

   task automatic test_hold();
      logic [8:0] e;
      for (int i = 0; i < 256; i++) pat[i] = 9'((i * 7) % 440);
      send_frame(256, 1'b1, 1'b0);
      for (int c = 0; c < 1000; c++) begin
         n_cmp++;
         if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ready cycle %0d: wr_ready=%0b, required 0", c, wr_ready);
         end
         issue_rd(8'($urandom_range(0, 255)));
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_data !== e) begin
            n_err++;
            $display("FAIL hold_rd cycle %0d: rd_data=%0d, required %0d", c, rd_data, e);
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_disp = !model_disp;
      n_cmp++;
      if (disp_bank !== model_disp || swap_pulse !== 1'b1) begin
         n_err++;
         $display("FAIL swap2: disp=%0b swap=%0b, required %0b 1", disp_bank, swap_pulse, model_disp);
      end
      for (int i = 0; i < 8; i++) begin
         issue_rd(8'(i * 37));
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_data !== e) begin
            n_err++;
            $display("FAIL frame2_rd addr %0d: rd_data=%0d, required %0d", i * 37, rd_data, e);
         end
      end
   endtask

   task automatic test_short_frame();
      logic [8:0] e;
      for (int i = 0; i < 256; i++) pat[i] = 9'(200 + i);
      send_frame(10, 1'b1, 1'b0);
      n_cmp++;
      if (wr_ready !== 1'b0 || frame_err !== 1'b1) begin
         n_err++;
         $display("FAIL short_frame: ready=%0b err=%0b, required 0 1", wr_ready, frame_err);
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_disp = !model_disp;
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a;
         a = (i == 0) ? 8'd0 : (i == 1) ? 8'd9 : (i == 2) ? 8'd10 : (i == 3) ? 8'd11 : (i == 4) ? 8'd128 : 8'd255;
         issue_rd(a);
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_data !== e) begin
            n_err++;
            $display("FAIL short_rd addr %0d: rd_data=%0d, required %0d", a, rd_data, e);
         end
      end
   endtask

   task automatic test_coincident();
      logic old_disp;
      old_disp = model_disp;
      for (int i = 0; i < 256; i++) pat[i] = 9'(255 - i);
      send_frame(256, 1'b1, 1'b1);
      n_cmp++;
      if (disp_bank !== old_disp || swap_pulse !== 1'b0 || wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL coincident_noswap: disp=%0b swap=%0b ready=%0b, required %0b 0 0",
                  disp_bank, swap_pulse, wr_ready, old_disp);
      end
      repeat (3) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_disp = !model_disp;
      n_cmp++;
      if (disp_bank !== !old_disp || swap_pulse !== 1'b1 || frame_err !== 1'b1) begin
         n_err++;
         $display("FAIL coincident_next: disp=%0b swap=%0b err=%0b, required %0b 1 1",
                  disp_bank, swap_pulse, frame_err, !old_disp);
      end
   endtask

   task automatic test_clamp();
      logic [8:0] e;
      for (int i = 0; i < 256; i++) pat[i] = 9'(i);
      pat[5] = 9'd511;
      send_frame(256, 1'b1, 1'b0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_disp = !model_disp;
      issue_rd(8'd5);
      e = exp_q.pop_front();
      n_cmp++;
`ifdef SPECTRUM_CLAMP_EN
      if (rd_data !== 9'd440 || e !== 9'd440) begin
         n_err++;
         $display("FAIL clamp_bin5: rd_data=%0d, required 440", rd_data);
      end
`else
      if (rd_data !== 9'd511 || e !== 9'd511) begin
         n_err++;
         $display("FAIL clamp_bin5: rd_data=%0d, required 511", rd_data);
      end
`endif
      issue_rd(8'd4);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== e) begin
         n_err++;
         $display("FAIL clamp_bin4: rd_data=%0d, required %0d", rd_data, e);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [8:0] e;
      for (int i = 0; i < 256; i++) pat[i] = 9'(300 + (i % 100));
      send_frame(20, 1'b0, 1'b0);
      wr_valid = 1'b1;
      wr_data  = 9'd77;
      #2 rst = 1'b1;
      #1;
      clear_model();
      n_cmp++;
      if (wr_ready !== 1'b0 || disp_bank !== 1'b0 || swap_pulse !== 1'b0 || frame_err !== 1'b0 || rd_data !== 9'd0) begin
         n_err++;
         $display("FAIL async_reset: ready=%0b disp=%0b swap=%0b err=%0b rd=%0d, required 0 0 0 0 0",
                  wr_ready, disp_bank, swap_pulse, frame_err, rd_data);
      end
      tick();
      rst = 1'b0;
      repeat (255) tick();
      n_cmp++;
      if (wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reinit_ready_256: wr_ready=%0b, required 0", wr_ready);
      end
      tick();
      wr_valid = 1'b0;
      n_cmp++;
      if (wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reinit_ready_257: wr_ready=%0b, required 1", wr_ready);
      end
      for (int i = 0; i < 4; i++) begin
         issue_rd(8'(i * 5));
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_data !== e) begin
            n_err++;
            $display("FAIL reinit_rd addr %0d: rd_data=%0d, required %0d", i * 5, rd_data, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_hold();
      test_short_frame();
      test_coincident();
      test_clamp();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
